udp_rx_frame_buf: RTL

//  Downstream of my_ip_receive. Buffers one received UDP payload (32-bit words, first byte in [31:24]).

---
 rtl/udp_rx_frame_buf_pkg.sv | 24 ++
 rtl/udp_rx_frame_buf_ram.sv | 23 ++
 rtl/udp_rx_frame_buf.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_frame_buf_pkg.sv
// Shared types and helpers for the UDP receive frame buffer.
// Imported by the buffer top and its testbench.
package udp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    READ  = 2'd3
  } state_t;

  localparam int CNT_W = 16;

  // Byte enables for the final word, MSB = first byte.
  function automatic logic [3:0] keep_from_len(input logic [1:0] len);
    case (len)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/udp_rx_frame_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Single clock; no reset on the storage or read register.
module sdp_ram #(
  parameter int W = 32,
  parameter int D = 256
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(D)-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic                 re,
  input  logic [$clog2(D)-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_rx_frame_buf.sv
// Buffers one UDP payload, commits it only if clean and complete,
// then replays it on a valid/ready stream with keep and last.
module udp_rx_frame_buf
  import udp_rx_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int ERR_WAIT = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rec_data_en,
  input  logic [31:0]      rec_data,
  input  logic             rec_end,
  input  logic [15:0]      rec_data_num,
  input  logic             err_flag,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic [3:0]       rd_keep,
  output logic             rd_last,
  output logic [15:0]      frm_len,
  output logic             frm_done,
  output logic             frm_drop,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ERR_WAIT + 1);

  state_t        state;
  logic [AW:0]   wr_ptr;
  logic [15:0]   rd_ptr;
  logic [15:0]   exp_words;
  logic [15:0]   exp_now;
  logic [15:0]   len_q;
  logic          bad;
  logic          ovf;
  logic          skip;
  logic [TW-1:0] wait_cnt;

  logic start, wbeat, skip_beat, skip_end;
  logic chk_last, fail, commit, chk_drop;
  logic [1:0]    n_drop;
  logic [CNT_W:0] dsum;

  assign exp_now   = (rec_data_num + 16'd3) >> 2;
  assign skip_beat = rec_data_en &&
                     (skip || state == CHECK || state == READ);
  assign start     = rec_data_en && !skip && state == IDLE;
  assign wbeat     = start || (rec_data_en && state == WRITE);
  assign skip_end  = skip_beat && rec_end;
  assign chk_last  = state == CHECK &&
                     wait_cnt == TW'(ERR_WAIT - 1);
  assign fail      = bad || err_flag || ovf ||
                     16'(wr_ptr) != exp_words;
  assign commit    = chk_last && !fail;
  assign chk_drop  = chk_last && fail;
  assign frm_drop  = chk_drop || skip_end;
  assign n_drop    = 2'(chk_drop) + 2'(skip_end);
  assign dsum      = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

  // Read side: RAM stage, output register and one prefetch slot.
  logic          ram_valid, ram_last;
  logic [3:0]    ram_keep;
  logic [31:0]   ram_q;
  logic          sk_valid, sk_last;
  logic [3:0]    sk_keep;
  logic [31:0]   sk_data;
  logic          pop, load_out, rd_issue, issue;
  logic [15:0]   iss_idx;
  logic          iss_last;
  logic [3:0]    iss_keep;

  assign pop      = rd_valid && rd_ready;
  assign load_out = !rd_valid || pop;
  assign frm_done = pop && rd_last;
  // Never have more words in flight than the two holding slots.
  assign rd_issue = state == READ && rd_ptr != exp_words &&
                    (2'(rd_valid) + 2'(sk_valid) + 2'(ram_valid)) <
                    (2'(pop) + 2'd2);
  assign issue    = commit || rd_issue;
  assign iss_idx  = commit ? 16'd0 : rd_ptr;
  assign iss_last = iss_idx == exp_words - 16'd1;
  assign iss_keep = iss_last ? keep_from_len(len_q[1:0]) : 4'hF;

  sdp_ram #(.W(32), .D(DEPTH)) u_ram (
    .clk   (sys_clk),
    .we    (wbeat && (start || !wr_ptr[AW])),
    .waddr (start ? '0 : wr_ptr[AW-1:0]),
    .wdata (rec_data),
    .re    (issue),
    .raddr (iss_idx[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exp_words <= '0;
      len_q     <= '0;
      bad       <= 1'b0;
      ovf       <= 1'b0;
      skip      <= 1'b0;
      wait_cnt  <= '0;
      frm_len   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (skip_beat) skip <= !rec_end;
      if (frm_drop)
        drop_cnt <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
      if (commit) rd_ptr <= 16'd1;
      else if (rd_issue) rd_ptr <= rd_ptr + 16'd1;
      unique case (state)
        IDLE: if (start) begin
          wr_ptr <= (AW+1)'(1);
          bad    <= err_flag;
          ovf    <= 1'b0;
          if (rec_end) begin
            exp_words <= exp_now;
            len_q     <= rec_data_num;
            wait_cnt  <= '0;
            state     <= CHECK;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (err_flag) bad <= 1'b1;
          if (rec_data_en) begin
            if (wr_ptr[AW]) ovf <= 1'b1;
            else wr_ptr <= wr_ptr + 1'b1;
            if (rec_end) begin
              exp_words <= exp_now;
              len_q     <= rec_data_num;
              wait_cnt  <= '0;
              state     <= CHECK;
            end
          end
        end
        CHECK: begin
          if (err_flag) bad <= 1'b1;
          wait_cnt <= wait_cnt + 1'b1;
          if (chk_last) state <= fail ? IDLE : READ;
          if (commit) frm_len <= len_q;
        end
        READ: if (frm_done) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_valid <= 1'b0;
      ram_last  <= 1'b0;
      ram_keep  <= '0;
      sk_valid  <= 1'b0;
      sk_last   <= 1'b0;
      sk_keep   <= '0;
      sk_data   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_keep   <= '0;
      rd_last   <= 1'b0;
    end else begin
      ram_valid <= issue;
      ram_last  <= iss_last;
      ram_keep  <= iss_keep;
      if (load_out) begin
        if (sk_valid) begin
          rd_valid <= 1'b1;
          rd_data  <= sk_data;
          rd_keep  <= sk_keep;
          rd_last  <= sk_last;
          sk_valid <= ram_valid;
          sk_data  <= ram_q;
          sk_keep  <= ram_keep;
          sk_last  <= ram_last;
        end else begin
          rd_valid <= ram_valid;
          if (ram_valid) begin
            rd_data <= ram_q;
            rd_keep <= ram_keep;
            rd_last <= ram_last;
          end
        end
      end else if (ram_valid) begin
        sk_valid <= 1'b1;
        sk_data  <= ram_q;
        sk_keep  <= ram_keep;
        sk_last  <= ram_last;
      end
    end
  end

endmodule
